// File: rtl/card_round_sched.sv
// Two-player round scheduler: arbitrates card requests onto one score accumulator and judges each round.
// Optional macro CARD_CHECK_EN rejects codes 0, 14 and 15 and pulses err for each rejected transfer.
module card_round_sched #(
  parameter int unsigned CARDS  = 5,
  parameter int unsigned TARGET = 21
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic       req1,
  input  logic [3:0] card1,
  input  logic       req2,
  input  logic [3:0] card2,
  output logic       gnt1,
  output logic       gnt2,
  output logic       out_valid,
  output logic       equal,
  output logic       winner,
  output logic       bust1,
  output logic       bust2,
  output logic       err
);

  localparam int unsigned CW = 3;
  localparam int unsigned SW = 7;

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] JUDGE   = 2'd1;
  localparam logic [1:0] REPORT  = 2'd2;

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt1, cnt2, cnt1_n, cnt2_n;
  logic [SW-1:0] sum1, sum2, sum1_n, sum2_n;
  logic          rr, rr_n;
  logic          cand1, cand2, take1, take2;
  logic          over1, over2, tie, win2;

  function automatic logic [SW-1:0] score(input logic [3:0] c);
    if (c > 4'd10) return SW'(10);
    return SW'(c);
  endfunction

  // Round-robin arbitration between eligible requesters
  assign cand1 = (state == COLLECT) && (cnt1 < CW'(CARDS)) && req1;
  assign cand2 = (state == COLLECT) && (cnt2 < CW'(CARDS)) && req2;
  assign gnt1  = cand1 && (!cand2 || !rr);
  assign gnt2  = cand2 && (!cand1 || rr);

`ifdef CARD_CHECK_EN
  function automatic logic legal(input logic [3:0] c);
    return (c != 4'd0) && (c < 4'd14);
  endfunction

  assign take1 = gnt1 && legal(card1);
  assign take2 = gnt2 && legal(card2);

  // Illegal transfers complete the handshake but only raise err
  always_ff @(posedge clk1) begin
    if (rst) err <= 1'b0;
    else     err <= (gnt1 && !legal(card1)) || (gnt2 && !legal(card2));
  end
`else
  assign take1 = gnt1;
  assign take2 = gnt2;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk1) begin
    if (rst) state <= COLLECT;
    else     state <= state_n;
  end

  // Next state and next accumulator values; the final accept moves straight to JUDGE
  always_comb begin
    state_n = state;
    cnt1_n  = cnt1;
    cnt2_n  = cnt2;
    sum1_n  = sum1;
    sum2_n  = sum2;
    rr_n    = rr;
    case (state)
      COLLECT: begin
        if (take1) begin
          cnt1_n = cnt1 + CW'(1);
          sum1_n = sum1 + score(card1);
          rr_n   = 1'b1;
        end
        if (take2) begin
          cnt2_n = cnt2 + CW'(1);
          sum2_n = sum2 + score(card2);
          rr_n   = 1'b0;
        end
        if ((cnt1_n == CW'(CARDS)) && (cnt2_n == CW'(CARDS))) state_n = JUDGE;
      end
      JUDGE:   state_n = REPORT;
      REPORT: begin
        state_n = COLLECT;
        cnt1_n  = '0;
        cnt2_n  = '0;
        sum1_n  = '0;
        sum2_n  = '0;
        rr_n    = 1'b0;
      end
      default: state_n = COLLECT;
    endcase
  end

  assign over1 = sum1 > SW'(TARGET);
  assign over2 = sum2 > SW'(TARGET);
  assign tie   = (over1 == over2) && (over1 || (sum1 == sum2));
  assign win2  = (over1 != over2) ? over1 : (sum2 > sum1);

  // Accumulators and judged results; results hold until the next JUDGE
  always_ff @(posedge clk1) begin
    if (rst) begin
      cnt1      <= '0;
      cnt2      <= '0;
      sum1      <= '0;
      sum2      <= '0;
      rr        <= 1'b0;
      out_valid <= 1'b0;
      equal     <= 1'b0;
      winner    <= 1'b0;
      bust1     <= 1'b0;
      bust2     <= 1'b0;
    end else begin
      cnt1      <= cnt1_n;
      cnt2      <= cnt2_n;
      sum1      <= sum1_n;
      sum2      <= sum2_n;
      rr        <= rr_n;
      out_valid <= (state == JUDGE);
      if (state == JUDGE) begin
        equal  <= tie;
        winner <= !tie && win2;
        bust1  <= over1;
        bust2  <= over2;
      end
    end
  end

endmodule

// File: tb/tb_card_round_sched.sv
// Scoreboard bench for card_round_sched: expected round results are queued at load time
// and compared when out_valid strobes. Honors CARD_CHECK_EN if defined for the build.
module tb_card_round_sched;

  logic       clk1 = 1'b0;
  logic       rst;
  logic       req1, req2;
  logic [3:0] card1, card2;
  logic       gnt1, gnt2, out_valid, equal, winner, bust1, bust2, err;

  typedef struct packed {
    logic equal;
    logic winner;
    logic bust1;
    logic bust2;
  } res_t;

  int tests = 0;
  int fails = 0;

  logic [3:0] p1q[$];
  logic [3:0] p2q[$];
  res_t       sb[$];
  int         grant_log[$];

  card_round_sched #(.CARDS(5), .TARGET(21)) dut (
    .clk1(clk1), .rst(rst),
    .req1(req1), .card1(card1), .req2(req2), .card2(card2),
    .gnt1(gnt1), .gnt2(gnt2), .out_valid(out_valid),
    .equal(equal), .winner(winner), .bust1(bust1), .bust2(bust2), .err(err)
  );

  always #5 clk1 = ~clk1;

  function automatic bit is_bad(input logic [3:0] c);
`ifdef CARD_CHECK_EN
    return (c == 4'd0) || (c >= 4'd14);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int card_pts(input logic [3:0] c);
    if (is_bad(c)) return 0;
    if (c >= 4'd11) return 10;
    return int'(c);
  endfunction

  // Load both hands and push the independently judged result
  task automatic load_round(input logic [3:0] a[5], input logic [3:0] b[5]);
    int s1 = 0, s2 = 0;
    bit o1, o2;
    res_t r;
    for (int i = 0; i < 5; i++) begin
      p1q.push_back(a[i]); s1 += card_pts(a[i]);
      p2q.push_back(b[i]); s2 += card_pts(b[i]);
    end
    o1 = s1 > 21;
    o2 = s2 > 21;
    r.bust1 = o1;
    r.bust2 = o2;
    if ((o1 && o2) || (!o1 && !o2 && s1 == s2)) begin
      r.equal = 1'b1; r.winner = 1'b0;
    end else if (o1 || o2) begin
      r.equal = 1'b0; r.winner = o1;
    end else begin
      r.equal = 1'b0; r.winner = (s2 > s1);
    end
    sb.push_back(r);
  endtask

  // Play queued cards; seq=1 makes player 2 wait until player 1 has nothing left
  task automatic feed(input bit seq, output int cycles);
    int guard = 0;
    bit g1, g2, prev_bad = 1'b0, now_bad;
    cycles = 0;
    grant_log.delete();
    while ((p1q.size() > 0 || p2q.size() > 0) && guard < 200) begin
      @(negedge clk1);
      req1  = (p1q.size() > 0);
      card1 = req1 ? p1q[0] : 4'd0;
      req2  = (p2q.size() > 0) && !(seq && p1q.size() > 0);
      card2 = req2 ? p2q[0] : 4'd0;
      #1;
      g1 = gnt1; g2 = gnt2;
      tests++;
      if ((g1 && g2) || (req1 && req2 && !g1 && !g2)) begin
        fails++; $display("FAIL grant_arb: gnt1=%0b gnt2=%0b req1=%0b req2=%0b", g1, g2, req1, req2);
      end
      tests++;
      if (err !== prev_bad) begin
        fails++; $display("FAIL err_pulse: got %0b want %0b", err, prev_bad);
      end
      now_bad = 1'b0;
      @(posedge clk1);
      if (req1 && g1) begin
        now_bad = is_bad(p1q[0]); void'(p1q.pop_front()); grant_log.push_back(1);
      end else if (req2 && g2) begin
        now_bad = is_bad(p2q[0]); void'(p2q.pop_front()); grant_log.push_back(2);
      end
      prev_bad = now_bad;
      cycles++; guard++;
    end
    @(negedge clk1);
    req1 = 1'b0; req2 = 1'b0;
    tests++;
    if (guard >= 200) begin
      fails++; $display("FAIL feed_timeout: %0d cards left", p1q.size() + p2q.size());
      p1q.delete(); p2q.delete();
    end else if (err !== prev_bad) begin
      fails++; $display("FAIL err_last: got %0b want %0b", err, prev_bad);
    end
  endtask

  // Called at the negedge after the last accept: strobe expected exactly one cycle later
  task automatic expect_result(input string name);
    res_t exp, got;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL %s_early: out_valid=%0b want 0", name, out_valid); end
    @(negedge clk1);
    tests++;
    if (sb.size() == 0) begin
      fails++; $display("FAIL %s_sb_empty: out_valid=%0b want no pending round", name, out_valid);
      return;
    end
    exp = sb.pop_front();
    got = '{equal, winner, bust1, bust2};
    if (out_valid !== 1'b1 || got !== exp) begin
      fails++; $display("FAIL %s_result: out_valid=%0b eq/win/b1/b2=%b want 1 %b", name, out_valid, got, exp);
    end
    @(negedge clk1);
    got = '{equal, winner, bust1, bust2};
    tests++;
    if (out_valid !== 1'b0 || got !== exp) begin
      fails++; $display("FAIL %s_hold: out_valid=%0b eq/win/b1/b2=%b want 0 %b", name, out_valid, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0; card1 = 4'd0; card2 = 4'd0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    tests++;
    if ({gnt1, gnt2, out_valid, equal, winner, bust1, bust2, err} !== 8'b0) begin
      fails++; $display("FAIL reset_outputs: got %b want 00000000",
                        {gnt1, gnt2, out_valid, equal, winner, bust1, bust2, err});
    end
    rst = 1'b0;
  endtask

  task automatic test_alternate();
    int cyc;
    load_round('{4'd10, 4'd4, 4'd3, 4'd2, 4'd1}, '{4'd5, 4'd5, 4'd4, 4'd3, 4'd2});
    feed(1'b0, cyc);
    expect_result("alternate");
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok = 1'b1;
    load_round('{4'd2, 4'd3, 4'd4, 4'd5, 4'd6}, '{4'd13, 4'd1, 4'd1, 4'd1, 4'd1});
    feed(1'b0, cyc);
    for (int i = 0; i < grant_log.size(); i++)
      if (grant_log[i] != ((i % 2 == 0) ? 1 : 2)) ok = 1'b0;
    tests++;
    if (!ok || cyc != 10 || grant_log.size() != 10) begin
      fails++; $display("FAIL b2b_order: alternating=%0b cycles=%0d grants=%0d want 1 10 10",
                        ok, cyc, grant_log.size());
    end
    expect_result("b2b");
  endtask

  task automatic test_bust();
    int cyc;
    load_round('{4'd10, 4'd10, 4'd2, 4'd2, 4'd1}, '{4'd3, 4'd3, 4'd3, 4'd3, 4'd3});
    feed(1'b0, cyc);
    expect_result("bust_one");
    load_round('{4'd10, 4'd10, 4'd2, 4'd2, 4'd1}, '{4'd11, 4'd12, 4'd1, 4'd1, 4'd2});
    feed(1'b0, cyc);
    expect_result("bust_both");
  endtask

  task automatic test_ineligible();
    int cyc;
    load_round('{4'd1, 4'd1, 4'd1, 4'd1, 4'd1}, '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2});
    for (int i = 0; i < 5; i++) p2q.pop_back();
    feed(1'b0, cyc);
    for (int i = 0; i < 3; i++) begin
      req1 = 1'b1; card1 = 4'd9;
      #1;
      tests++;
      if (gnt1 !== 1'b0 || out_valid !== 1'b0) begin
        fails++; $display("FAIL inelig_gnt: gnt1=%0b out_valid=%0b want 0 0", gnt1, out_valid);
      end
      @(negedge clk1);
    end
    req1 = 1'b0;
    for (int i = 0; i < 5; i++) p2q.push_back(4'd2);
    feed(1'b1, cyc);
    expect_result("inelig");
  endtask

  task automatic test_mid_reset();
    int cyc;
    bit seen = 1'b0;
    for (int i = 0; i < 4; i++) p1q.push_back(4'd9);
    for (int i = 0; i < 3; i++) p2q.push_back(4'd9);
    feed(1'b0, cyc);
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk1);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin fails++; $display("FAIL midreset_strobe: out_valid seen=1 want 0"); end
    load_round('{4'd6, 4'd6, 4'd2, 4'd2, 4'd2}, '{4'd5, 4'd5, 4'd5, 4'd2, 4'd1});
    feed(1'b0, cyc);
    expect_result("midreset_round");
  endtask

  task automatic test_card15();
    int cyc, n1 = 0;
    load_round('{4'd15, 4'd1, 4'd1, 4'd1, 4'd1}, '{4'd4, 4'd4, 4'd4, 4'd1, 4'd1});
`ifdef CARD_CHECK_EN
    // the rejected code needs a replacement transfer; 10 keeps the sum at 14
    p1q.push_back(4'd10);
    sb[sb.size()-1] = '{1'b1, 1'b0, 1'b0, 1'b0};
`endif
    feed(1'b0, cyc);
    foreach (grant_log[i]) if (grant_log[i] == 1) n1++;
    tests++;
`ifdef CARD_CHECK_EN
    if (n1 != 6) begin fails++; $display("FAIL card15_count: p1 transfers=%0d want 6", n1); end
`else
    if (n1 != 5) begin fails++; $display("FAIL card15_count: p1 transfers=%0d want 5", n1); end
`endif
    expect_result("card15");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_alternate();
    test_bust();
    test_ineligible();
    test_mid_reset();
    test_card15();
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL sb_leftover: %0d pending want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
